// File: rtl/commit_multi.sv
// commit_multi
//   In-order retirement unit. Each cycle it retires the longest eligible
//   prefix of a COMMIT_WIDTH-entry window taken from the ROB head. The window
//   feeds the ARF write ports, the free list, the LSU store port and the
//   branch predictor. A retiring mispredicted branch starts a registered
//   flush of FLUSH_CYCLES cycles.
//
// Ports (W = COMMIT_WIDTH; slot i of a flattened field is [i*FW +: FW])
//   clk, rst                      clock; asynchronous active-low reset
//   rob_head_idx                  ROB index of slot 0
//   rob_win_*                     per-slot window contents from the ROB
//   commit_store_ready            LSU can accept a store commit
//   rob_commit_count              entries retired this cycle
//   arf_we/arf_waddr/arf_wdata    ARF write ports
//   free_phys_reg/freed_phys_reg  free-list return ports
//   commit_store_valid/_rob_idx   LSU store commit
//   update_bp/_pc/_taken          branch predictor update
//   flush_pipeline/redirect_pc    registered recovery outputs
//   retired_count/mispredict_count  performance counters (wrap)
//
// state | meaning
// ------+--------------------------------------------------------
// IDLE  | normal retirement
// FLUSH | pipeline flush in progress, redirect_pc valid, no retire

module commit_multi #(
  parameter int COMMIT_WIDTH    = 2,
  parameter int FLUSH_CYCLES    = 2,
  parameter int CNT_W           = 32,
  parameter int ROB_IDX_W       = 4,
  parameter int INSTR_MEM_IDX_W = 8,
  parameter int ARCH_REG_IDX_W  = 5,
  parameter int PHYS_REG_IDX_W  = 6,
  parameter int INT_DATA_W      = 32,
  localparam int W  = COMMIT_WIDTH,
  localparam int CW = $clog2(COMMIT_WIDTH + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ROB_IDX_W-1:0]         rob_head_idx,
  input  logic [W-1:0]                 rob_win_valid,
  input  logic [W-1:0]                 rob_win_done,
  input  logic [W-1:0]                 rob_win_is_store,
  input  logic [W-1:0]                 rob_win_is_branch,
  input  logic [W-1:0]                 rob_win_pred_taken,
  input  logic [W-1:0]                 rob_win_branch_taken,
  input  logic [W*INSTR_MEM_IDX_W-1:0] rob_win_pc,
  input  logic [W*INSTR_MEM_IDX_W-1:0] rob_win_pred_target,
  input  logic [W*INSTR_MEM_IDX_W-1:0] rob_win_branch_target,
  input  logic [W*ARCH_REG_IDX_W-1:0]  rob_win_logical_rd,
  input  logic [W*PHYS_REG_IDX_W-1:0]  rob_win_old_phys_rd,
  input  logic [W*INT_DATA_W-1:0]      rob_win_result,
  input  logic                         commit_store_ready,
  output logic [CW-1:0]                rob_commit_count,
  output logic [W-1:0]                 arf_we,
  output logic [W*ARCH_REG_IDX_W-1:0]  arf_waddr,
  output logic [W*INT_DATA_W-1:0]      arf_wdata,
  output logic [W-1:0]                 free_phys_reg,
  output logic [W*PHYS_REG_IDX_W-1:0]  freed_phys_reg,
  output logic                         commit_store_valid,
  output logic [ROB_IDX_W-1:0]         commit_store_rob_idx,
  output logic                         update_bp,
  output logic                         update_bp_taken,
  output logic [INSTR_MEM_IDX_W-1:0]   update_bp_pc,
  output logic                         flush_pipeline,
  output logic [INSTR_MEM_IDX_W-1:0]   redirect_pc,
  output logic [CNT_W-1:0]             retired_count,
  output logic [CNT_W-1:0]             mispredict_count
);

  localparam int PW = INSTR_MEM_IDX_W;
  localparam int AW = ARCH_REG_IDX_W;
  localparam int RW = PHYS_REG_IDX_W;
  localparam int DW = INT_DATA_W;
  localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

  typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} state_t;

  state_t        state, state_d;
  logic [3:0]    flush_cnt, flush_cnt_d;
  logic [PW-1:0] redirect_q;
  logic [W-1:0]  mispred;
  logic [W-1:0]  retire;
  logic          mispredict_fire;
  logic [PW-1:0] next_pc;

  always_comb begin
    mispred = '0;
    for (int i = 0; i < W; i++) begin
      mispred[i] = rob_win_is_branch[i] &&
                   ((rob_win_pred_taken[i] != rob_win_branch_taken[i]) ||
                    (rob_win_branch_taken[i] &&
                     (rob_win_pred_target[i*PW +: PW] != rob_win_branch_target[i*PW +: PW])));
    end
  end

  // Walk the window oldest-first; the first slot that cannot retire stops
  // everything younger. Reset is folded in so the outputs are quiet while
  // rst is held, independent of the window contents.
  always_comb begin
    logic stop;
    logic store_used;
    logic branch_used;
    retire      = '0;
    stop        = (state != IDLE) || !rst;
    store_used  = 1'b0;
    branch_used = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (stop || !rob_win_valid[i] || !rob_win_done[i]) begin
        stop = 1'b1;
      end else if (rob_win_is_store[i] && (store_used || !commit_store_ready)) begin
        stop = 1'b1;
      end else if (rob_win_is_branch[i] && branch_used) begin
        stop = 1'b1;
      end else begin
        retire[i] = 1'b1;
        if (rob_win_is_store[i])  store_used  = 1'b1;
        if (rob_win_is_branch[i]) branch_used = 1'b1;
        // younger slots are on the wrong path
        if (mispred[i]) stop = 1'b1;
      end
    end
  end

  always_comb begin
    rob_commit_count     = '0;
    arf_we               = '0;
    arf_waddr            = '0;
    arf_wdata            = '0;
    free_phys_reg        = '0;
    freed_phys_reg       = '0;
    commit_store_valid   = 1'b0;
    commit_store_rob_idx = '0;
    update_bp            = 1'b0;
    update_bp_taken      = 1'b0;
    update_bp_pc         = '0;
    mispredict_fire      = 1'b0;
    next_pc              = '0;
    for (int i = 0; i < W; i++) begin
      if (retire[i]) begin
        // retire is a contiguous prefix, so the last set slot gives the count
        rob_commit_count = CW'(i + 1);
        if (rob_win_logical_rd[i*AW +: AW] != '0) begin
          arf_we[i]              = 1'b1;
          arf_waddr[i*AW +: AW]  = rob_win_logical_rd[i*AW +: AW];
          arf_wdata[i*DW +: DW]  = rob_win_result[i*DW +: DW];
          free_phys_reg[i]       = 1'b1;
          freed_phys_reg[i*RW +: RW] = rob_win_old_phys_rd[i*RW +: RW];
        end
        if (rob_win_is_store[i]) begin
          commit_store_valid   = 1'b1;
          commit_store_rob_idx = rob_head_idx + ROB_IDX_W'(i);
        end
        if (rob_win_is_branch[i]) begin
          update_bp       = 1'b1;
          update_bp_taken = rob_win_branch_taken[i];
          update_bp_pc    = rob_win_pc[i*PW +: PW];
        end
        if (mispred[i]) begin
          mispredict_fire = 1'b1;
          next_pc = rob_win_branch_taken[i] ? rob_win_branch_target[i*PW +: PW]
                                            : rob_win_pc[i*PW +: PW] + PW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      flush_cnt <= '0;
    end else begin
      state     <= state_d;
      flush_cnt <= flush_cnt_d;
    end
  end

  always_comb begin
    state_d     = state;
    flush_cnt_d = flush_cnt;
    case (state)
      IDLE: begin
        if (mispredict_fire) begin
          state_d     = FLUSH;
          flush_cnt_d = FLUSH_LAST;
        end
      end
      FLUSH: begin
        if (flush_cnt == '0) begin
          state_d = IDLE;
        end else begin
          flush_cnt_d = flush_cnt - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    flush_pipeline = (state == FLUSH);
    redirect_pc    = (state == FLUSH) ? redirect_q : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      redirect_q       <= '0;
      retired_count    <= '0;
      mispredict_count <= '0;
    end else begin
      retired_count <= retired_count + CNT_W'(rob_commit_count);
      if (mispredict_fire) begin
        redirect_q       <= next_pc;
        mispredict_count <= mispredict_count + CNT_W'(1);
      end
    end
  end

endmodule
